// File: rtl/floo_meta_table.sv
// Remaps incoming IDs onto NumOutIds outgoing IDs and keeps per-transaction metadata in one
// FIFO per outgoing ID. Optional error reporting is enabled by FLOO_META_TABLE_ERR_EN.
module floo_meta_table #(
  parameter int unsigned NumOutIds    = 4,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned IdInWidth    = 4,
  parameter int unsigned BufWidth     = 32,
  parameter int unsigned IdOutWidth   = $clog2(NumOutIds)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [IdInWidth-1:0]  req_id_i,
  input  logic [BufWidth-1:0]   req_buf_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [IdOutWidth-1:0] req_id_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [IdOutWidth-1:0] rsp_id_i,
  input  logic                  rsp_last_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IdInWidth-1:0]  rsp_id_o,
  output logic [BufWidth-1:0]   rsp_buf_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);
  localparam int unsigned PtrWidth = (MaxTxnsPerId > 1) ? $clog2(MaxTxnsPerId) : 1;

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [PtrWidth-1:0] ptr_t;

  logic [IdInWidth-1:0]  in_id_q  [NumOutIds];
  logic [IdInWidth-1:0]  in_id_d  [NumOutIds];
  cnt_t                  cnt_q    [NumOutIds];
  cnt_t                  cnt_d    [NumOutIds];
  ptr_t                  rd_ptr_q [NumOutIds];
  ptr_t                  rd_ptr_d [NumOutIds];
  ptr_t                  wr_ptr_q [NumOutIds];
  ptr_t                  wr_ptr_d [NumOutIds];
  logic [BufWidth-1:0]   mem_q    [NumOutIds][MaxTxnsPerId];
  logic                  lock_q, lock_d;
  logic [IdOutWidth-1:0] lock_id_q, lock_id_d;

  logic                  hit, hit_ok, free_found, can_alloc;
  logic [IdOutWidth-1:0] hit_idx, free_idx, sel;
  logic                  push, pop, rsp_empty;
  logic [NumOutIds-1:0]  push_vec, pop_vec;
  cnt_t                  rsp_cnt;
  logic [IdInWidth-1:0]  rsp_in_id;
  logic [BufWidth-1:0]   rsp_head;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(MaxTxnsPerId - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // A full hit entry stalls rather than falling back to a free entry, preserving order.
  always_comb begin
    hit        = 1'b0;
    hit_ok     = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned e = 0; e < NumOutIds; e++) begin
      if (!hit && cnt_q[e] != '0 && in_id_q[e] == req_id_i) begin
        hit     = 1'b1;
        hit_ok  = cnt_q[e] < cnt_t'(MaxTxnsPerId);
        hit_idx = IdOutWidth'(e);
      end
      if (!free_found && cnt_q[e] == '0) begin
        free_found = 1'b1;
        free_idx   = IdOutWidth'(e);
      end
    end
    if (lock_q) begin
      sel       = lock_id_q;
      can_alloc = 1'b1;
    end else if (hit) begin
      sel       = hit_idx;
      can_alloc = hit_ok;
    end else begin
      sel       = free_idx;
      can_alloc = free_found;
    end
    can_alloc = can_alloc & ~rst_i;
  end

  assign req_valid_o = req_valid_i & can_alloc;
  assign req_ready_o = req_ready_i & can_alloc;
  assign req_id_o    = sel;
  assign push        = req_valid_o & req_ready_i;

  always_comb begin
    rsp_cnt   = '0;
    rsp_in_id = '0;
    rsp_head  = '0;
    for (int unsigned e = 0; e < NumOutIds; e++) begin
      if (rsp_id_i == IdOutWidth'(e)) begin
        rsp_cnt   = cnt_q[e];
        rsp_in_id = in_id_q[e];
        rsp_head  = mem_q[e][rd_ptr_q[e]];
      end
    end
  end

  assign rsp_empty = (rsp_cnt == '0);
  assign rsp_id_o  = rsp_in_id;
  assign rsp_buf_o = rsp_head;
  // Responses to an empty entry never pop, whether or not errors are reported.
  assign pop       = rsp_valid_i & rsp_ready_i & rsp_last_i & ~rsp_empty;

`ifdef FLOO_META_TABLE_ERR_EN
  logic err_q;
  assign rsp_valid_o = rsp_valid_i & ~rsp_empty;
  assign rsp_ready_o = rsp_ready_i | rsp_empty;
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (rsp_valid_i && rsp_empty) begin
      err_q <= 1'b1;
    end
  end
`else
  assign rsp_valid_o = rsp_valid_i;
  assign rsp_ready_o = rsp_ready_i;
  assign err_o       = 1'b0;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    in_id_d   = in_id_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    push_vec  = '0;
    pop_vec   = '0;
    busy_o    = 1'b0;
    lock_d    = req_valid_o & ~req_ready_i;
    lock_id_d = sel;
    for (int unsigned e = 0; e < NumOutIds; e++) begin
      push_vec[e] = push && (sel == IdOutWidth'(e));
      pop_vec[e]  = pop && (rsp_id_i == IdOutWidth'(e));
      busy_o      = busy_o | (cnt_q[e] != '0);
      if (push_vec[e]) begin
        in_id_d[e]  = req_id_i;
        wr_ptr_d[e] = ptr_inc(wr_ptr_q[e]);
      end
      if (pop_vec[e]) begin
        rd_ptr_d[e] = ptr_inc(rd_ptr_q[e]);
      end
      if (push_vec[e] && !pop_vec[e]) begin
        cnt_d[e] = cnt_q[e] + cnt_t'(1);
      end else if (!push_vec[e] && pop_vec[e]) begin
        cnt_d[e] = cnt_q[e] - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_id_q   <= '{default: '0};
      cnt_q     <= '{default: '0};
      rd_ptr_q  <= '{default: '0};
      wr_ptr_q  <= '{default: '0};
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      in_id_q   <= in_id_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned e = 0; e < NumOutIds; e++) begin
      if (push_vec[e]) begin
        mem_q[e][wr_ptr_q[e]] <= req_buf_i;
      end
    end
  end

endmodule

// File: tb/tb_floo_meta_table.sv
// Randomised and directed bench for floo_meta_table against a queue-based reference model.
module tb_floo_meta_table;
  localparam int NumOut = 4;
  localparam int MaxTxn = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  logic [3:0]  req_id_i;
  logic [31:0] req_buf_i;
  logic [1:0]  req_id_o, rsp_id_i;
  logic        rsp_valid_i, rsp_ready_o, rsp_last_i, rsp_valid_o, rsp_ready_i;
  logic [3:0]  rsp_id_o;
  logic [31:0] rsp_buf_o;
  logic        busy_o, err_o;

  floo_meta_table #(
    .NumOutIds(4), .MaxTxnsPerId(4), .IdInWidth(4), .BufWidth(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
    .req_buf_i(req_buf_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_id_o(req_id_o), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_id_i(rsp_id_i), .rsp_last_i(rsp_last_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o), .rsp_buf_o(rsp_buf_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: one queue of buffers per outgoing ID plus its owner incoming ID.
  logic [3:0]  m_in_id [NumOut];
  logic [31:0] m_q [NumOut][$];
  bit          m_lock, m_err;
  int          m_lock_id;

  int checks = 0, failures = 0;
  bit check_en = 1'b0;
  bit last_push;
  logic c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready, c_busy, c_err;
  logic [1:0]  c_req_id;
  logic [3:0]  c_rsp_id;
  logic [31:0] c_rsp_buf;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_sel(input logic [3:0] id, output bit ok, output int idx);
    ok = 1'b0;
    idx = 0;
    if (m_lock) begin
      ok = 1'b1;
      idx = m_lock_id;
      return;
    end
    for (int e = 0; e < NumOut; e++) begin
      if (m_q[e].size() > 0 && m_in_id[e] == id) begin
        ok = (m_q[e].size() < MaxTxn);
        idx = e;
        return;
      end
    end
    for (int e = 0; e < NumOut; e++) begin
      if (m_q[e].size() == 0) begin
        ok = 1'b1;
        idx = e;
        return;
      end
    end
  endfunction

  task automatic step(input bit rst, input bit rv, input logic [3:0] rid, input logic [31:0] rbuf,
                      input bit rr, input bit sv, input logic [1:0] sid, input bit sl,
                      input bit sr);
    bit ok, e_rv, e_rr, nonempty, busy;
    int idx;
    @(negedge clk_i);
    rst_i = rst; req_valid_i = rv; req_id_i = rid; req_buf_i = rbuf; req_ready_i = rr;
    rsp_valid_i = sv; rsp_id_i = sid; rsp_last_i = sl; rsp_ready_i = sr;
    #1;
    c_req_valid = req_valid_o; c_req_ready = req_ready_o; c_req_id = req_id_o;
    c_rsp_valid = rsp_valid_o; c_rsp_ready = rsp_ready_o; c_rsp_id = rsp_id_o;
    c_rsp_buf = rsp_buf_o; c_busy = busy_o; c_err = err_o;
    model_sel(rid, ok, idx);
    if (rst) ok = 1'b0;
    e_rv = rv & ok;
    e_rr = rr & ok;
    nonempty = (m_q[sid].size() > 0);
    busy = 1'b0;
    for (int e = 0; e < NumOut; e++) busy |= (m_q[e].size() > 0);
    if (check_en) begin
      chk("req_valid_o", 64'(c_req_valid), 64'(e_rv));
      chk("req_ready_o", 64'(c_req_ready), 64'(e_rr));
      if (e_rv) chk("req_id_o", 64'(c_req_id), 64'(idx));
`ifdef FLOO_META_TABLE_ERR_EN
      chk("rsp_valid_o", 64'(c_rsp_valid), 64'(sv & nonempty));
      chk("rsp_ready_o", 64'(c_rsp_ready), 64'(sr | !nonempty));
      chk("err_o", 64'(c_err), 64'(m_err));
`else
      chk("rsp_valid_o", 64'(c_rsp_valid), 64'(sv));
      chk("rsp_ready_o", 64'(c_rsp_ready), 64'(sr));
      chk("err_o", 64'(c_err), 64'(0));
`endif
      if (sv && nonempty) begin
        chk("rsp_id_o", 64'(c_rsp_id), 64'(m_in_id[sid]));
        chk("rsp_buf_o", 64'(c_rsp_buf), 64'(m_q[sid][0]));
      end
      chk("busy_o", 64'(c_busy), 64'(busy));
    end
    last_push = e_rv & rr;
    @(posedge clk_i);
    if (rst) begin
      for (int e = 0; e < NumOut; e++) m_q[e].delete();
      m_lock = 1'b0;
      m_err = 1'b0;
    end else begin
`ifdef FLOO_META_TABLE_ERR_EN
      if (sv && !nonempty) m_err = 1'b1;
`endif
      if (sv && sr && sl && nonempty) void'(m_q[sid].pop_front());
      if (last_push) begin
        m_q[idx].push_back(rbuf);
        m_in_id[idx] = rid;
      end
      m_lock = e_rv & !rr;
      m_lock_id = idx;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic req(input logic [3:0] id, input logic [31:0] b, input bit rr);
    step(1'b0, 1'b1, id, b, rr, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic rsp(input logic [1:0] id, input bit last);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, id, last, 1'b1);
  endtask

  task automatic drain();
    for (int e = 0; e < NumOut; e++) begin
      while (m_q[e].size() > 0) rsp(2'(e), 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend = 1'b0;
    logic [3:0] pend_id = '0;
    logic [31:0] pend_buf = '0;
    for (int e = 0; e < NumOut; e++) m_in_id[e] = '0;
    m_lock = 1'b0; m_err = 1'b0; m_lock_id = 0;

    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check_en = 1'b1;
    step(1'b1, 1'b1, 4'd3, 32'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("rst_req_valid", 64'(c_req_valid), 64'(0));
    chk("rst_req_ready", 64'(c_req_ready), 64'(0));
    chk("rst_busy", 64'(c_busy), 64'(0));
    chk("rst_err", 64'(c_err), 64'(0));

    // Same-ID ordering
    req(4'd3, 32'hA, 1'b1); chk("ord_id_a", 64'(c_req_id), 64'(0));
    req(4'd3, 32'hB, 1'b1); chk("ord_id_b", 64'(c_req_id), 64'(0));
    req(4'd3, 32'hC, 1'b1); chk("ord_id_c", 64'(c_req_id), 64'(0));
    rsp(2'd0, 1'b1); chk("ord_buf_a", 64'(c_rsp_buf), 64'hA); chk("ord_rid", 64'(c_rsp_id), 64'(3));
    rsp(2'd0, 1'b1); chk("ord_buf_b", 64'(c_rsp_buf), 64'hB);
    rsp(2'd0, 1'b1); chk("ord_buf_c", 64'(c_rsp_buf), 64'hC);
    idle(); chk("ord_busy", 64'(c_busy), 64'(0));

    // Full entry stalls until a last-beat pop
    for (int i = 0; i < 4; i++) begin
      req(4'd5, 32'h5000_0000 + 32'(i), 1'b1);
      chk("full_id", 64'(c_req_id), 64'(0));
    end
    req(4'd5, 32'h5000_0004, 1'b1);
    chk("full_stall_valid", 64'(c_req_valid), 64'(0));
    chk("full_stall_ready", 64'(c_req_ready), 64'(0));
    step(1'b0, 1'b1, 4'd5, 32'h5000_0004, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
    chk("full_stall_pop", 64'(c_req_valid), 64'(0));
    req(4'd5, 32'h5000_0004, 1'b1);
    chk("full_accept", 64'(c_req_valid), 64'(1)); chk("full_accept_id", 64'(c_req_id), 64'(0));
    rsp(2'd0, 1'b0); chk("nonlast_buf", 64'(c_rsp_buf), 64'h5000_0001);
    rsp(2'd0, 1'b1); chk("nonlast_nopop", 64'(c_rsp_buf), 64'h5000_0001);
    drain();

    // Table full, then reuse of a freed middle entry
    for (int i = 0; i < 4; i++) begin
      req(4'(i + 1), 32'h100 + 32'(i), 1'b1);
      chk("tbl_id", 64'(c_req_id), 64'(i));
    end
    req(4'd7, 32'h777, 1'b1); chk("tbl_stall", 64'(c_req_valid), 64'(0));
    step(1'b0, 1'b1, 4'd7, 32'h777, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1);
    chk("tbl_stall_pop", 64'(c_req_valid), 64'(0));
    req(4'd7, 32'h777, 1'b1); chk("tbl_reuse_id", 64'(c_req_id), 64'(2));
    rsp(2'd2, 1'b1); chk("tbl_rsp_id", 64'(c_rsp_id), 64'(7));
    chk("tbl_rsp_buf", 64'(c_rsp_buf), 64'h777);
    drain();

    // Out-of-order return across IDs
    req(4'd1, 32'hF00D_0001, 1'b1); chk("ooo_x_id", 64'(c_req_id), 64'(0));
    req(4'd2, 32'hF00D_0002, 1'b1); chk("ooo_y_id", 64'(c_req_id), 64'(1));
    rsp(2'd1, 1'b1); chk("ooo_y_buf", 64'(c_rsp_buf), 64'hF00D_0002);
    chk("ooo_y_rid", 64'(c_rsp_id), 64'(2));
    rsp(2'd0, 1'b1); chk("ooo_x_buf", 64'(c_rsp_buf), 64'hF00D_0001);
    chk("ooo_x_rid", 64'(c_rsp_id), 64'(1));

    // Lock keeps req_id_o stable while a lower entry frees
    req(4'd4, 32'h44, 1'b1);
    req(4'd9, 32'h99, 1'b0); chk("lock_id0", 64'(c_req_id), 64'(1));
    step(1'b0, 1'b1, 4'd9, 32'h99, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
    chk("lock_id1", 64'(c_req_id), 64'(1));
    req(4'd9, 32'h99, 1'b0); chk("lock_id2", 64'(c_req_id), 64'(1));
    req(4'd9, 32'h99, 1'b1); chk("lock_hs_id", 64'(c_req_id), 64'(1));
    chk("lock_hs_ready", 64'(c_req_ready), 64'(1));
    drain();

    // Reset mid-transaction drops state
    req(4'd6, 32'h66, 1'b1);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(); chk("midrst_busy", 64'(c_busy), 64'(0));

`ifdef FLOO_META_TABLE_ERR_EN
    req(4'd6, 32'h66, 1'b1);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    chk("err_drop_valid", 64'(c_rsp_valid), 64'(0));
    chk("err_drop_ready", 64'(c_rsp_ready), 64'(1));
    idle(); chk("err_set", 64'(c_err), 64'(1));
    idle(); chk("err_sticky", 64'(c_err), 64'(1));
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(); chk("err_rst", 64'(c_err), 64'(0)); chk("err_rst_busy", 64'(c_busy), 64'(0));
`endif

    // Randomised traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit rst, rr, sv, sl, sr;
      int e;
      rst = ($urandom_range(0, 499) == 0);
      if (rst) pend = 1'b0;
      if (!rst && !pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        pend_id = 4'($urandom_range(0, 5));
        pend_buf = $urandom;
      end
      rr = ($urandom_range(0, 3) != 0);
      e = int'($urandom_range(0, NumOut - 1));
      sv = (m_q[e].size() > 0) && ($urandom_range(0, 1) == 1);
      sl = ($urandom_range(0, 1) == 1);
      sr = ($urandom_range(0, 3) != 0);
      step(rst, pend, pend_id, pend_buf, rr, sv, 2'(e), sl, sr);
      if (last_push) pend = 1'b0;
    end

    drain();
    idle(); chk("final_busy", 64'(c_busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
